encoder: RTL and testbench

//  Rank-order (intensity-to-latency) spike encoder at the input of the SNN accelerator.
//  - On NEW_IMAGE it captures a full image.
//  - It emits one AER event per non-zero pixel, brightest first; each event carries the pixel index.
//  - Downstream sink: the input layer of the SNN core, over a 4-phase AER link.

---
 rtl/encoder_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 35 +++
 rtl/encoder.sv | 169 ++++++++++++++++
 tb/tb_encoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// ----------------------------------------------------------------------------
// encoder_pkg
//   Shared types and default sizes for the rank-order spike encoder.
//   - enc_state_t : encoder FSM states
//   - DEF_*       : default parameter values of the encoder top
//   - pixel_t     : one pixel at the default width (PIXEL_BITS+1 bits)
//   - aer_addr_t  : AER event address at the default width (MSB always 0)
// ----------------------------------------------------------------------------
package encoder_pkg;

    localparam int DEF_IMAGE_SIZE      = 256;
    localparam int DEF_IMAGE_SIZE_BITS = 8;
    localparam int DEF_PIXEL_MAX_VALUE = 255;
    localparam int DEF_PIXEL_BITS      = 8;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        REQ,
        REL,
        DONE
    } enc_state_t;

    typedef logic [DEF_PIXEL_BITS:0]      pixel_t;
    typedef logic [DEF_IMAGE_SIZE_BITS:0] aer_addr_t;

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
//   Single-bit two-flop synchronizer for a signal asynchronous to clk.
//   Ports:
//     clk : destination clock
//     rst : synchronous, active-high reset (both flops cleared)
//     d   : asynchronous input
//     q   : synchronized output, two clk cycles of latency
// ----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbour, giving a real
    // two-stage pipeline instead of a single wire-through.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/encoder.sv
// ----------------------------------------------------------------------------
// encoder
//   Rank-order (intensity-to-latency) spike encoder. A NEW_IMAGE request
//   captures the whole image; the encoder then sweeps a threshold from
//   PIXEL_MAX_VALUE down to 1 and, for each threshold, scans pixel indices
//   in ascending order, emitting one 4-phase AER event per matching pixel.
//   Result: brightest first, ties in ascending index, zero and out-of-range
//   pixels never emitted.
//   Ports:
//     CLK           : clock, all logic on posedge
//     RST           : synchronous, active-high reset
//     IMAGE         : pixel array, index 0..IMAGE_SIZE-1, PIXEL_BITS+1 bits each
//     NEW_IMAGE     : start request, accepted in IDLE or DONE
//     IMAGE_ENCODED : level, high once all events of the image were sent
//     AEROUT_ADDR   : event address = pixel index (MSB always 0)
//     AEROUT_REQ    : AER request
//     AEROUT_ACK    : AER acknowledge, asynchronous to CLK
// ----------------------------------------------------------------------------
module encoder
    import encoder_pkg::*;
#(
    parameter int IMAGE_SIZE      = DEF_IMAGE_SIZE,
    parameter int IMAGE_SIZE_BITS = DEF_IMAGE_SIZE_BITS,
    parameter int PIXEL_MAX_VALUE = DEF_PIXEL_MAX_VALUE,
    parameter int PIXEL_BITS      = DEF_PIXEL_BITS
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [PIXEL_BITS:0]      IMAGE [0:IMAGE_SIZE-1],
    input  logic                     NEW_IMAGE,
    output logic                     IMAGE_ENCODED,
    output logic [IMAGE_SIZE_BITS:0] AEROUT_ADDR,
    output logic                     AEROUT_REQ,
    input  logic                     AEROUT_ACK
);

    localparam logic [IMAGE_SIZE_BITS-1:0] LAST_IDX = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
    localparam logic [IMAGE_SIZE_BITS-1:0] IDX_ONE  = IMAGE_SIZE_BITS'(1);
    localparam logic [PIXEL_BITS:0]        THR_MAX  = (PIXEL_BITS + 1)'(PIXEL_MAX_VALUE);
    localparam logic [PIXEL_BITS:0]        THR_ONE  = (PIXEL_BITS + 1)'(1);

    logic ack_s;

    sync_2ff u_ack_sync (
        .clk (CLK),
        .rst (RST),
        .d   (AEROUT_ACK),
        .q   (ack_s)
    );

    enc_state_t                 state_q, state_d;
    logic [IMAGE_SIZE_BITS-1:0] idx_q,   idx_d;
    logic [PIXEL_BITS:0]        thr_q,   thr_d;
    logic                       req_q,   req_d;
    logic [IMAGE_SIZE_BITS:0]   addr_q,  addr_d;
    logic                       enc_q,   enc_d;
    logic [PIXEL_BITS:0]        img_q [0:IMAGE_SIZE-1];
    logic [PIXEL_BITS:0]        img_d [0:IMAGE_SIZE-1];
    logic                       capture;

    // Scan-position advance shared by SCAN (no match) and REL (event done).
    logic                       last_idx;
    logic                       adv_done;
    logic [IMAGE_SIZE_BITS-1:0] idx_adv;
    logic [PIXEL_BITS:0]        thr_adv;

    always_comb begin
        last_idx = (idx_q == LAST_IDX);
        // Wrapping the index from threshold 1 would reach threshold 0: finished.
        adv_done = last_idx && (thr_q == THR_ONE);
        idx_adv  = last_idx ? '0 : idx_q + IDX_ONE;
        thr_adv  = last_idx ? thr_q - THR_ONE : thr_q;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        idx_d   = idx_q;
        thr_d   = thr_q;
        req_d   = req_q;
        addr_d  = addr_q;
        enc_d   = enc_q;
        capture = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (NEW_IMAGE) begin
                    capture = 1'b1;
                    thr_d   = THR_MAX;
                    idx_d   = '0;
                    enc_d   = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (img_q[idx_q] == thr_q) begin
                    // A stray ACK still high would make the new request look
                    // acknowledged; hold the match until the link is idle.
                    if (!ack_s) begin
                        addr_d  = {1'b0, idx_q};
                        req_d   = 1'b1;
                        state_d = REQ;
                    end
                end else if (adv_done) begin
                    enc_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_adv;
                    thr_d = thr_adv;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REL;
                end
            end
            REL: begin
                if (!ack_s) begin
                    if (adv_done) begin
                        enc_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_adv;
                        thr_d   = thr_adv;
                        state_d = SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < IMAGE_SIZE; i++) begin
            img_d[i] = capture ? IMAGE[i] : img_q[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            thr_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            enc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            thr_q   <= thr_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            enc_q   <= enc_d;
        end
    end

    // NOTE: the image store has no reset; it is only read after a capture
    // has overwritten every entry, so clearing it would add nothing.
    always_ff @(posedge CLK) begin
        img_q <= img_d;
    end

    assign AEROUT_REQ    = req_q;
    assign AEROUT_ADDR   = addr_q;
    assign IMAGE_ENCODED = enc_q;

endmodule

// File: tb/tb_encoder.sv
// ----------------------------------------------------------------------------
// tb_encoder
//   Self-checking bench for the rank-order encoder on a reduced image
//   (32 pixels, max intensity 31, 6-bit pixels) so each full threshold sweep
//   stays short. An AER sink answers requests with a programmable delay and
//   records every event; expected event lists come from a table or from a
//   sort-based reference model.
// ----------------------------------------------------------------------------
module tb_encoder;

    localparam int N    = 32;
    localparam int NB   = 5;
    localparam int PMAX = 31;
    localparam int PB   = 5;

    logic          CLK;
    logic          RST;
    logic [PB:0]   image [0:N-1];
    logic          NEW_IMAGE;
    logic          IMAGE_ENCODED;
    logic [NB:0]   AEROUT_ADDR;
    logic          AEROUT_REQ;
    logic          AEROUT_ACK;

    encoder #(
        .IMAGE_SIZE      (N),
        .IMAGE_SIZE_BITS (NB),
        .PIXEL_MAX_VALUE (PMAX),
        .PIXEL_BITS      (PB)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .IMAGE         (image),
        .NEW_IMAGE     (NEW_IMAGE),
        .IMAGE_ENCODED (IMAGE_ENCODED),
        .AEROUT_ADDR   (AEROUT_ADDR),
        .AEROUT_REQ    (AEROUT_REQ),
        .AEROUT_ACK    (AEROUT_ACK)
    );

    initial begin
        CLK = 1'b0;
        forever #5ns CLK = ~CLK;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          ev_q[$];
    int          exp_q[$];
    int          viol = 0;
    int          ack_delay = 1;
    bit          ack_auto = 1'b1;
    bit          req_prev = 1'b0;
    logic [NB:0] addr_hold = '0;
    logic [PB:0] img_buf [0:N-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // AER sink: raise ACK a delay after REQ, drop it a delay after REQ falls.
    initial begin
        AEROUT_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            if (ack_auto && AEROUT_REQ === 1'b1) begin
                #(ack_delay * 1ns);
                AEROUT_ACK = 1'b1;
                for (int n = 0; n < 400 && AEROUT_REQ !== 1'b0; n++) @(negedge CLK);
                #(ack_delay * 1ns);
                AEROUT_ACK = 1'b0;
            end
        end
    end

    // Event recorder and handshake-rule monitor.
    always @(negedge CLK) begin
        if (AEROUT_REQ === 1'b1 && !req_prev) begin
            ev_q.push_back(int'(AEROUT_ADDR));
            addr_hold = AEROUT_ADDR;
            if (AEROUT_ACK !== 1'b0) viol++;
        end else if (AEROUT_REQ === 1'b1 && AEROUT_ADDR !== addr_hold) begin
            viol++;
        end
        req_prev = (AEROUT_REQ === 1'b1);
    end

    // Reference model: key = value*N + (N-1-index); sorting keys descending
    // gives brightest first with ties in ascending index.
    task automatic build_expected();
        int keys[$];
        for (int i = 0; i < N; i++) begin
            if (img_buf[i] != 0 && int'(img_buf[i]) <= PMAX)
                keys.push_back(int'(img_buf[i]) * N + (N - 1 - i));
        end
        keys.rsort();
        exp_q.delete();
        foreach (keys[k]) exp_q.push_back(N - 1 - (keys[k] % N));
    endtask

    task automatic clear_buf();
        for (int i = 0; i < N; i++) img_buf[i] = '0;
    endtask

    task automatic run_image(input string name, input int delay, input bit poke);
        int budget;
        int cyc;
        ev_q.delete();
        viol      = 0;
        ack_delay = delay;
        budget    = N * PMAX + exp_q.size() * (delay / 2 + 40) + 100;
        @(negedge CLK);
        for (int i = 0; i < N; i++) image[i] = img_buf[i];
        NEW_IMAGE = 1'b1;
        @(negedge CLK);
        NEW_IMAGE = 1'b0;
        for (int i = 0; i < N; i++) image[i] = (PB + 1)'($urandom);
        check({name, " encoded cleared"}, IMAGE_ENCODED, 0);
        if (poke) begin
            repeat (3) @(negedge CLK);
            for (int i = 0; i < N; i++) image[i] = (PB + 1)'(PMAX);
            NEW_IMAGE = 1'b1;
            @(negedge CLK);
            NEW_IMAGE = 1'b0;
        end
        cyc = 0;
        while (IMAGE_ENCODED !== 1'b1 && cyc < budget) begin
            @(negedge CLK);
            cyc++;
        end
        check({name, " done"}, IMAGE_ENCODED, 1);
        check({name, " count"}, ev_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("%s ev%0d addr", name, k),
                  (k < ev_q.size()) ? ev_q[k] : -1, exp_q[k]);
        end
        repeat (5) @(negedge CLK);
        check({name, " hold encoded"}, IMAGE_ENCODED, 1);
        check({name, " idle req"}, AEROUT_REQ, 0);
        check({name, " handshake"}, viol, 0);
    endtask

    typedef struct {
        int n_set;
        int set_idx[4];
        int set_val[4];
        int delay;
        int n_exp;
        int exp_addr[4];
    } vec_t;

    vec_t vecs[6];

    initial begin
        int bad;
        int cyc;

        // {pixels set, ack delay (ns), expected events}
        vecs[0] = '{1, '{31, 0, 0, 0},  '{1, 0, 0, 0},     1,   1, '{31, 0, 0, 0}};
        vecs[1] = '{3, '{3, 7, 20, 0},  '{16, 16, 16, 0},  1,   3, '{3, 7, 20, 0}};
        vecs[2] = '{3, '{9, 0, 5, 0},   '{31, 2, 31, 0},   1,   3, '{5, 9, 0, 0}};
        vecs[3] = '{3, '{4, 10, 2, 0},  '{63, 40, 1, 0},   1,   1, '{2, 0, 0, 0}};
        vecs[4] = '{0, '{0, 0, 0, 0},   '{0, 0, 0, 0},     1,   0, '{0, 0, 0, 0}};
        vecs[5] = '{4, '{1, 30, 15, 16}, '{7, 7, 20, 31},  100, 4, '{16, 15, 1, 30}};

        RST       = 1'b1;
        NEW_IMAGE = 1'b0;
        for (int i = 0; i < N; i++) image[i] = (PB + 1)'(i);

        // Reset for 100 ns, with a start request asserted during it.
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            NEW_IMAGE = (c >= 3);
            if (AEROUT_REQ !== 1'b0 || AEROUT_ADDR !== '0 || IMAGE_ENCODED !== 1'b0) bad++;
        end
        NEW_IMAGE = 1'b0;
        RST       = 1'b0;
        check("reset outputs", bad, 0);
        check("reset no events", ev_q.size(), 0);
        repeat (3) @(negedge CLK);
        check("post-reset req", AEROUT_REQ, 0);
        check("post-reset addr", AEROUT_ADDR, 0);
        check("post-reset encoded", IMAGE_ENCODED, 0);

        // Table-driven sparse images.
        for (int v = 0; v < 6; v++) begin
            clear_buf();
            for (int s = 0; s < vecs[v].n_set; s++)
                img_buf[vecs[v].set_idx[s]] = (PB + 1)'(vecs[v].set_val[s]);
            exp_q.delete();
            for (int e = 0; e < vecs[v].n_exp; e++) exp_q.push_back(vecs[v].exp_addr[e]);
            run_image($sformatf("vec%0d", v), vecs[v].delay, 1'b0);
        end

        // Digit-like image, unique maximum 30 at index 9.
        for (int i = 0; i < N; i++)
            img_buf[i] = (i % 5 == 0) ? '0 : (PB + 1)'((i % 4) * 6 + 3);
        img_buf[9] = (PB + 1)'(30);
        build_expected();
        run_image("digit", 1, 1'b0);
        check("digit first addr", (ev_q.size() > 0) ? ev_q[0] : -1, 9);
        bad = 0;
        for (int k = 1; k < ev_q.size(); k++) begin
            if (img_buf[ev_q[k-1]] < img_buf[ev_q[k]]) bad++;
            else if (img_buf[ev_q[k-1]] == img_buf[ev_q[k]] && ev_q[k-1] >= ev_q[k]) bad++;
        end
        check("digit order", bad, 0);

        // Random images, random sink speed.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                if (r == 3) img_buf[i] = (PB + 1)'($urandom_range(0, 63));
                else img_buf[i] = ($urandom_range(0, 9) < 4) ? (PB + 1)'($urandom_range(1, 63)) : '0;
            end
            build_expected();
            run_image($sformatf("rand%0d", r), $urandom_range(1, 40), 1'b0);
        end

        // Reset while a request is pending, then restart.
        clear_buf();
        img_buf[6]  = (PB + 1)'(31);
        img_buf[2]  = (PB + 1)'(20);
        img_buf[20] = (PB + 1)'(5);
        ack_auto = 1'b0;
        ev_q.delete();
        @(negedge CLK);
        for (int i = 0; i < N; i++) image[i] = img_buf[i];
        NEW_IMAGE = 1'b1;
        @(negedge CLK);
        NEW_IMAGE = 1'b0;
        cyc = 0;
        while (AEROUT_REQ !== 1'b1 && cyc < 4 * N) begin
            @(negedge CLK);
            cyc++;
        end
        check("rst req pending", AEROUT_REQ, 1);
        check("rst pending addr", AEROUT_ADDR, 6);
        RST = 1'b1;
        @(negedge CLK);
        check("rst req dropped", AEROUT_REQ, 0);
        check("rst encoded", IMAGE_ENCODED, 0);
        check("rst addr", AEROUT_ADDR, 0);
        RST      = 1'b0;
        ack_auto = 1'b1;
        repeat (3 * N) @(negedge CLK);
        check("rst image dropped", ev_q.size(), 1);
        check("rst stays idle", IMAGE_ENCODED, 0);
        build_expected();
        run_image("restart", 1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
